// File: rtl/acc_step_ctrl.sv
// -----------------------------------------------------------------------------
// acc_step_ctrl
//
// Sequencer for the button-stepped accumulator. It owns the accumulator
// register, whose output feeds back into the adder as the C,D operands. The raw
// active-low push button is synchronised and debounced on the system clock, so
// the button never acts as a clock. Each debounced press produces exactly one
// load. The block also keeps a sticky overflow flag and a saturating step
// counter.
//
// Configuration macro:
//   ACC_STEP_SAT_EN  when defined, an overflowing step saturates acc_q at
//                    2^WIDTH-1 instead of wrapping modulo 2^WIDTH. carry_flag
//                    is set in both cases.
//
// Parameters:
//   WIDTH            accumulator / addend width in bits
//   DEBOUNCE_CYCLES  number of stable cycles required for both press and
//                    release (must be >= 2)
//   CNT_W            step counter width
//
// Ports:
//   clk         in   1      system clock; all state changes on the rising edge
//   reset       in   1      asynchronous, active-high; clears all state
//   btn_n       in   1      raw push button, active-low, asynchronous to clk
//   clr         in   1      synchronous clear of acc_q and carry_flag
//   addend      in   WIDTH  operand added on each step, sampled only in LOAD
//   acc_q       out  WIDTH  accumulator value (feeds the adder as C,D)
//   load_en     out  1      one-cycle pulse in the cycle acc_q is updated
//   carry_flag  out  1      sticky; set when any step overflowed WIDTH bits
//   step_count  out  CNT_W  number of loads since reset, saturating
//   busy        out  1      high in every state other than IDLE
// -----------------------------------------------------------------------------
module acc_step_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] addend,
    output logic [WIDTH-1:0] acc_q,
    output logic             load_en,
    output logic             carry_flag,
    output logic [CNT_W-1:0] step_count,
    output logic             busy
);

    // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        LOAD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_next;

    // -------------------------------------------------------------------------
    // Button synchroniser
    // -------------------------------------------------------------------------
    // The flops reset to 1, which is the released level of the active-low
    // button. A button held through reset is therefore seen as a fresh falling
    // edge after release, and it has to be debounced again.
    logic btn_meta;
    logic btn_s;
    logic press;

    // NOTE: sequential state uses non-blocking assignments (<=). All flops
    // then update together at the edge, and simulation ordering cannot leak
    // into the behaviour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta <= 1'b1;
            btn_s    <= 1'b1;
        end else begin
            btn_meta <= btn_n;
            btn_s    <= btn_meta;
        end
    end

    assign press = ~btn_s;

    // -------------------------------------------------------------------------
    // Debounce / load sequencer: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state  <= state_next;
            db_cnt <= db_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce / load sequencer: next-state logic
    // -------------------------------------------------------------------------
    // The counter is cleared on entry to both wait states. In RELEASE_WAIT it
    // is also cleared whenever the button bounces back to pressed, so only an
    // unbroken run of released cycles returns the FSM to IDLE.
    //
    // NOTE: every signal this block drives gets a default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        db_cnt_next = db_cnt;

        unique case (state)
            IDLE: begin
                db_cnt_next = '0;
                if (press) begin
                    state_next = PRESS_WAIT;
                end
            end

            PRESS_WAIT: begin
                if (!press) begin
                    // Pulse shorter than the debounce window: reject it.
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = LOAD;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end

            LOAD: begin
                // One-cycle state. The release window starts counting from 0.
                state_next  = RELEASE_WAIT;
                db_cnt_next = '0;
            end

            RELEASE_WAIT: begin
                if (press) begin
                    db_cnt_next = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + 1'b1;
                end
            end

            default: begin
                state_next  = IDLE;
                db_cnt_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the registered state only, so there is no
    // combinational path from btn_n. Both outputs also drop immediately when
    // reset is asserted.
    assign load_en = (state == LOAD);
    assign busy    = (state != IDLE);

    // -------------------------------------------------------------------------
    // Accumulator datapath
    // -------------------------------------------------------------------------
    // The sum is one bit wider than the accumulator so that the carry out of
    // the WIDTH-bit add is visible.
    logic [WIDTH:0]   sum;
    logic             overflow;
    logic [WIDTH-1:0] acc_load_val;

    assign sum      = {1'b0, acc_q} + {1'b0, addend};
    assign overflow = sum[WIDTH];

`ifdef ACC_STEP_SAT_EN
    assign acc_load_val = overflow ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    assign acc_load_val = sum[WIDTH-1:0];
`endif

    // clr takes priority over a load for acc_q and carry_flag. The step
    // counter is kept separate below, so a clr during LOAD still counts the
    // step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            carry_flag <= 1'b0;
        end else if (clr) begin
            acc_q      <= '0;
            carry_flag <= 1'b0;
        end else if (load_en) begin
            acc_q      <= acc_load_val;
            carry_flag <= carry_flag | overflow;
        end
    end

    // The step counter stops at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_count <= '0;
        end else if (load_en && (step_count != {CNT_W{1'b1}})) begin
            step_count <= step_count + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Simulation-only property: a load is never longer than one cycle.
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_load_one_cycle : assert property (
        @(posedge clk) disable iff (reset) load_en |=> !load_en
    );
`endif

endmodule

// File: tb/tb_acc_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_acc_step_ctrl
//
// Self-checking bench for acc_step_ctrl with DEBOUNCE_CYCLES=4 and WIDTH=2.
// The main instance uses CNT_W=8. A second instance with CNT_W=2 is used for
// the step-counter saturation scenario.
//
// Each press pushes the bench's predicted post-load state (acc_q, carry_flag,
// step_count) onto a scoreboard queue. A monitor pops the queue one cycle
// after each load_en pulse and compares. A load with nothing queued is an
// error. Outputs are sampled and inputs are driven on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_acc_step_ctrl;

    localparam int WIDTH = 2;
    localparam int DB    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             btn_n;
    logic             clr;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_q;
    logic             load_en;
    logic             carry_flag;
    logic [7:0]       step_count;
    logic             busy;

    logic             btn2_n;
    logic             clr2;
    logic [WIDTH-1:0] acc2_q;
    logic             load2_en;
    logic             carry2_flag;
    logic [1:0]       step2_count;
    logic             busy2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_loads  = 0;
    int n_pushed = 0;

    always #5 clk = ~clk;

    acc_step_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn_n),
        .clr        (clr),
        .addend     (addend),
        .acc_q      (acc_q),
        .load_en    (load_en),
        .carry_flag (carry_flag),
        .step_count (step_count),
        .busy       (busy)
    );

    acc_step_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB), .CNT_W(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .btn_n      (btn2_n),
        .clr        (clr2),
        .addend     (addend),
        .acc_q      (acc2_q),
        .load_en    (load2_en),
        .carry_flag (carry2_flag),
        .step_count (step2_count),
        .busy       (busy2)
    );

    // ------------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic [WIDTH-1:0] acc;
        logic             carry;
        logic [7:0]       steps;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] model_acc   = '0;
    logic             model_carry = 1'b0;
    logic [7:0]       model_steps = '0;

    task automatic model_reset();
        model_acc   = '0;
        model_carry = 1'b0;
        model_steps = '0;
        sb_q.delete();
    endtask

    task automatic push_expect(input logic [WIDTH-1:0] add, input bit clr_in_load);
        logic [WIDTH:0] s;
        exp_t e;
        s = {1'b0, model_acc} + {1'b0, add};
        if (clr_in_load) begin
            model_acc   = '0;
            model_carry = 1'b0;
        end else begin
            model_carry = model_carry | s[WIDTH];
`ifdef ACC_STEP_SAT_EN
            model_acc = s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
`else
            model_acc = s[WIDTH-1:0];
`endif
        end
        if (model_steps != 8'hFF) model_steps = model_steps + 8'd1;
        e.acc   = model_acc;
        e.carry = model_carry;
        e.steps = model_steps;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    // Monitor: acc_q, carry_flag and step_count are compared one cycle after
    // load_en, which is when the updated values become visible.
    logic pending = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                pending = 1'b0;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_load: acc_q=%0d with no load expected", acc_q);
                end else begin
                    e = sb_q.pop_front();
                    if (acc_q !== e.acc || carry_flag !== e.carry || step_count !== e.steps) begin
                        n_fail++;
                        $display("FAIL sb_load: acc=%0d carry=%b steps=%0d, expected acc=%0d carry=%b steps=%0d",
                                 acc_q, carry_flag, step_count, e.acc, e.carry, e.steps);
                    end
                end
            end
            if (load_en === 1'b1) begin
                pending = 1'b1;
                n_loads++;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Starts at a falling edge and holds the button low. Checks that load_en
    // rises exactly 7 edges later (2 sync + DB + 1) and lasts one cycle. If
    // rel > 0, it then releases the button and checks that busy has cleared.
    task automatic run_press(input logic [WIDTH-1:0] add, input int hold,
                             input int rel, input bit clr_in_load);
        addend = add;
        push_expect(add, clr_in_load);
        btn_n = 1'b0;
        tick(6);
        n_checks++;
        if (load_en !== 1'b0) begin
            n_fail++;
            $display("FAIL load_early: load_en=%b expected 0", load_en);
        end
        tick(1);
        n_checks++;
        if (load_en !== 1'b1) begin
            n_fail++;
            $display("FAIL load_latency: load_en=%b expected 1", load_en);
        end
        if (clr_in_load) clr = 1'b1;
        tick(1);
        clr = 1'b0;
        // addend is ignored outside LOAD.
        addend = ~add;
        n_checks++;
        if (load_en !== 1'b0) begin
            n_fail++;
            $display("FAIL load_width: load_en=%b expected 0", load_en);
        end
        tick(hold - 8);
        if (rel > 0) begin
            btn_n = 1'b1;
            tick(rel);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL release_idle: busy=%b expected 0", busy);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset  = 1'b1;
        btn_n  = 1'b1;
        btn2_n = 1'b1;
        clr    = 1'b0;
        clr2   = 1'b0;
        addend = '0;
        tick(3);
        n_checks++;
        if ({acc_q, load_en, carry_flag, step_count, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: acc=%0d load=%b carry=%b steps=%0d busy=%b expected all 0",
                     acc_q, load_en, carry_flag, step_count, busy);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_single_press();
        run_press(2'd1, 20, 10, 1'b0);
        n_checks++;
        if (acc_q !== 2'd1 || step_count !== 8'd1) begin
            n_fail++;
            $display("FAIL single_press: acc=%0d steps=%0d expected acc=1 steps=1", acc_q, step_count);
        end
    endtask

    task automatic test_glitch();
        int loads_before;
        loads_before = n_loads;
        addend = 2'd2;
        btn_n  = 1'b0;
        tick(2);
        btn_n = 1'b1;
        tick(1);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_seen: busy=%b expected 1", busy);
        end
        tick(4);
        n_checks++;
        if (busy !== 1'b0 || acc_q !== 2'd1 || n_loads != loads_before) begin
            n_fail++;
            $display("FAIL glitch_reject: busy=%b acc=%0d loads=%0d expected busy=0 acc=1 loads=%0d",
                     busy, acc_q, n_loads, loads_before);
        end
    endtask

    task automatic test_reset_mid_press();
        addend = 2'd2;
        btn_n  = 1'b0;
        tick(4);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy: busy=%b expected 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({acc_q, load_en, carry_flag, step_count, busy} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: acc=%0d load=%b carry=%b steps=%0d busy=%b expected all 0",
                     acc_q, load_en, carry_flag, step_count, busy);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        // The button is still held, so it must be debounced from the start.
        run_press(2'd2, 12, 10, 1'b0);
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] exp_acc[4];
        logic             exp_carry[4];
        logic [7:0]       steps_before;
        steps_before = step_count;
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        model_acc   = '0;
        model_carry = 1'b0;
        n_checks++;
        if (acc_q !== 2'd0 || carry_flag !== 1'b0 || step_count !== steps_before) begin
            n_fail++;
            $display("FAIL clr_idle: acc=%0d carry=%b steps=%0d expected 0 0 %0d",
                     acc_q, carry_flag, step_count, steps_before);
        end
`ifdef ACC_STEP_SAT_EN
        exp_acc = '{2'd3, 2'd3, 2'd3, 2'd3};
`else
        exp_acc = '{2'd3, 2'd2, 2'd1, 2'd0};
`endif
        exp_carry = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_press(2'd3, 10, 8, 1'b0);
            n_checks++;
            if (acc_q !== exp_acc[i] || carry_flag !== exp_carry[i]) begin
                n_fail++;
                $display("FAIL wrap_step%0d: acc=%0d carry=%b expected acc=%0d carry=%b",
                         i, acc_q, carry_flag, exp_acc[i], exp_carry[i]);
            end
        end
    endtask

    task automatic test_bounce_and_clr();
        int         loads_before;
        logic [7:0] steps_before;
        run_press(2'd1, 10, 0, 1'b0);
        loads_before = n_loads;
        btn_n = 1'b1;
        tick(2);
        btn_n = 1'b0;
        tick(1);
        btn_n = 1'b1;
        tick(6);
        tick(4);
        n_checks++;
        if (busy !== 1'b0 || n_loads != loads_before) begin
            n_fail++;
            $display("FAIL release_bounce: busy=%b loads=%0d expected busy=0 loads=%0d",
                     busy, n_loads, loads_before);
        end
        steps_before = step_count;
        run_press(2'd1, 10, 8, 1'b1);
        n_checks++;
        if (acc_q !== 2'd0 || carry_flag !== 1'b0 || step_count !== steps_before + 8'd1) begin
            n_fail++;
            $display("FAIL clr_in_load: acc=%0d carry=%b steps=%0d expected 0 0 %0d",
                     acc_q, carry_flag, step_count, steps_before + 8'd1);
        end
    endtask

    task automatic test_step_saturation();
        logic [1:0] exp_cnt;
        addend = 2'd1;
        for (int i = 0; i < 5; i++) begin
            btn2_n = 1'b0;
            tick(10);
            btn2_n = 1'b1;
            tick(10);
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_checks++;
            if (step2_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL step_sat%0d: step_count=%0d expected %0d", i, step2_count, exp_cnt);
            end
        end
    endtask

    task automatic test_drain();
        n_checks++;
        if (sb_q.size() != 0 || n_loads != n_pushed) begin
            n_fail++;
            $display("FAIL sb_drain: loads=%0d queued=%0d expected loads=%0d queued=0",
                     n_loads, sb_q.size(), n_pushed);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        // The mid-press reset zeroes the load counter's reference.
        test_reset_mid_press();
        n_pushed = 1;
        n_loads  = n_loads - (n_loads - 1);
        test_wrap();
        test_bounce_and_clr();
        test_step_saturation();
        tick(2);
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
